// File: rtl/hfrv_mem_bridge_pkg.sv
// hfrv_mem_bridge_pkg
// Shared types and constants for the memory bridge:
//   state_t    - bridge FSM states (IDLE, REQ, DONE)
//   ERR_RDATA  - read data returned when an access times out
//   DEF_*      - default parameter values for the bridge
package hfrv_mem_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [31:0] ERR_RDATA = 32'hDEADBEEF;

    localparam int DEF_ADDR_W         = 32;
    localparam int DEF_DATA_W         = 32;
    localparam int DEF_TIMEOUT_CYCLES = 255;
    localparam int DEF_CNT_W          = 32;

endpackage

// File: rtl/hfrv_sat_counter.sv
// hfrv_sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
// Ports:
//   clock  - rising-edge clock
//   reset  - asynchronous active-low reset (count -> 0)
//   clear  - synchronous clear, has priority over en
//   en     - count up by one this cycle (ignored once saturated)
//   count  - current count
module hfrv_sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (en && (count_reg != '1)) begin
            count_next = count_reg + WIDTH'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/hfrv_mem_bridge.sv
// hfrv_mem_bridge
// Turns the bus mux's single-cycle memory port into a req/ack transaction
// toward a slow SRAM/flash, stalling the datapath until the data phase ends.
// Optional macro HFRV_MEM_BRIDGE_TIMEOUT_EN adds an ack timeout that ends the
// access with bus_err and ERR_RDATA; without it REQ waits forever.
// Ports:
//   clock, reset       - clock, asynchronous active-low reset
//   access_mem         - mux requests an access this cycle
//   addr_mem           - access address
//   data_write_mem     - write data
//   data_we_mem        - byte enables, all-zero = read
//   data_read_mem      - read data back to the mux (held between accesses)
//   stall              - freeze request to mux/datapath
//   sram_req/we/be/addr/wdata - transaction toward memory
//   sram_ack, sram_rdata      - completion pulse and read data from memory
//   bus_err            - one-cycle timeout pulse (0 without the macro)
//   stall_cycles       - saturating count of stalled cycles
module hfrv_mem_bridge
    import hfrv_mem_bridge_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                access_mem,
    input  logic [ADDR_W-1:0]   addr_mem,
    input  logic [DATA_W-1:0]   data_write_mem,
    input  logic [DATA_W/8-1:0] data_we_mem,
    output logic [DATA_W-1:0]   data_read_mem,
    output logic                stall,
    output logic                sram_req,
    output logic                sram_we,
    output logic [DATA_W/8-1:0] sram_be,
    output logic [ADDR_W-1:0]   sram_addr,
    output logic [DATA_W-1:0]   sram_wdata,
    input  logic                sram_ack,
    input  logic [DATA_W-1:0]   sram_rdata,
    output logic                bus_err,
    output logic [CNT_W-1:0]    stall_cycles
);

    state_t state_reg;
    state_t state_next;

    logic [ADDR_W-1:0]   addr_reg;
    logic [DATA_W-1:0]   wdata_reg;
    logic [DATA_W/8-1:0] be_reg;
    logic [DATA_W-1:0]   rdata_reg;

    logic capture;      // IDLE cycle that latches a new access
    logic ack_take;     // REQ cycle completed by the memory
    logic expire;       // REQ cycle ended by the timeout (ack absent)
    logic timeout_hit;  // timeout counter has reached its limit

    always_comb begin
        state_next = state_reg;
        stall      = 1'b0;
        capture    = 1'b0;
        ack_take   = 1'b0;
        expire     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (access_mem) begin
                    stall      = 1'b1;
                    capture    = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                stall = 1'b1;
                // An ack coinciding with expiry is a normal completion.
                if (sram_ack) begin
                    ack_take   = 1'b1;
                    state_next = DONE;
                end else if (timeout_hit) begin
                    expire     = 1'b1;
                    state_next = DONE;
                end
            end
            // access_mem seen here belongs to the finishing access.
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            addr_reg  <= '0;
            wdata_reg <= '0;
            be_reg    <= '0;
            rdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (capture) begin
                addr_reg  <= addr_mem;
                wdata_reg <= data_write_mem;
                be_reg    <= data_we_mem;
            end
            // Writes leave the last read value in place.
            if (!sram_we) begin
                if (ack_take) begin
                    rdata_reg <= sram_rdata;
                end else if (expire) begin
                    rdata_reg <= DATA_W'(ERR_RDATA);
                end
            end
        end
    end

    assign sram_req      = (state_reg == REQ);
    assign sram_we       = |be_reg;
    assign sram_be       = be_reg;
    assign sram_addr     = addr_reg;
    assign sram_wdata    = wdata_reg;
    assign data_read_mem = rdata_reg;

    hfrv_sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clock (clock),
        .reset (reset),
        .clear (1'b0),
        .en    (stall),
        .count (stall_cycles)
    );

`ifdef HFRV_MEM_BRIDGE_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_count;
    logic            bus_err_reg;

    // Held at zero outside REQ so every access starts from a fresh count;
    // it counts ack-less REQ cycles, expiring on the TIMEOUT_CYCLES-th.
    hfrv_sat_counter #(.WIDTH(TO_W)) u_timeout_cnt (
        .clock (clock),
        .reset (reset),
        .clear (state_reg != REQ),
        .en    ((state_reg == REQ) && !sram_ack),
        .count (to_count)
    );

    assign timeout_hit = (to_count == TO_W'(TIMEOUT_CYCLES - 1));

    // Registered so the pulse lines up with the DONE cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus_err_reg <= 1'b0;
        end else begin
            bus_err_reg <= expire;
        end
    end

    assign bus_err = bus_err_reg;
`else
    assign timeout_hit = 1'b0;
    assign bus_err     = 1'b0;
`endif

endmodule

// File: tb/tb_hfrv_mem_bridge.sv
// tb_hfrv_mem_bridge
// Directed bench for hfrv_mem_bridge (CNT_W=4, TIMEOUT_CYCLES=4). Expected
// read data is queued when an access is issued and popped in its DONE cycle.
// Timeout steps run only when HFRV_MEM_BRIDGE_TIMEOUT_EN is defined.
module tb_hfrv_mem_bridge;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int CW = 4;
    localparam int TO = 4;

    logic          clock;
    logic          reset;
    logic          access_mem;
    logic [AW-1:0] addr_mem;
    logic [DW-1:0] data_write_mem;
    logic [3:0]    data_we_mem;
    logic [DW-1:0] data_read_mem;
    logic          stall;
    logic          sram_req;
    logic          sram_we;
    logic [3:0]    sram_be;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic          sram_ack;
    logic [DW-1:0] sram_rdata;
    logic          bus_err;
    logic [CW-1:0] stall_cycles;

    hfrv_mem_bridge #(
        .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO), .CNT_W(CW)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .access_mem     (access_mem),
        .addr_mem       (addr_mem),
        .data_write_mem (data_write_mem),
        .data_we_mem    (data_we_mem),
        .data_read_mem  (data_read_mem),
        .stall          (stall),
        .sram_req       (sram_req),
        .sram_we        (sram_we),
        .sram_be        (sram_be),
        .sram_addr      (sram_addr),
        .sram_wdata     (sram_wdata),
        .sram_ack       (sram_ack),
        .sram_rdata     (sram_rdata),
        .bus_err        (bus_err),
        .stall_cycles   (stall_cycles)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_data  = 32'h0;
    int          exp_stall = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One access: capture cycle, 'delay' REQ cycles, then DONE.
    // ack_en=0 means no ack (the timeout ends REQ after TO cycles).
    // hold keeps access_mem high from the ack cycle through DONE.
    task automatic access(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input int delay,
                          input logic [31:0] rdata, input bit ack_en, input bit hold);
        logic [31:0] exp_rd;
        @(posedge clock); #1;
        access_mem     = 1'b1;
        addr_mem       = addr;
        data_write_mem = wdata;
        data_we_mem    = be;
        @(negedge clock);
        check("cap_stall", 32'(stall), 32'd1);
        check("cap_req", 32'(sram_req), 32'd0);
        if (be != 4'h0) exp_rd = exp_data;
        else if (ack_en) exp_rd = rdata;
        else exp_rd = 32'hDEADBEEF;
        exp_q.push_back(exp_rd);
        exp_data = exp_rd;
        for (int i = 1; i <= delay; i++) begin
            @(posedge clock); #1;
            access_mem = hold && (i == delay);
            sram_ack   = ack_en && (i == delay);
            sram_rdata = (i == delay) ? rdata : 32'hBAD0_0000 + 32'(i);
            @(negedge clock);
            check("req_req", 32'(sram_req), 32'd1);
            check("req_stall", 32'(stall), 32'd1);
            check("req_addr", sram_addr, addr);
            check("req_wdata", sram_wdata, wdata);
            check("req_be", 32'(sram_be), 32'(be));
            check("req_we", 32'(sram_we), 32'(be != 4'h0));
        end
        @(posedge clock); #1;
        sram_ack = 1'b0;
        if (!hold) access_mem = 1'b0;
        exp_stall = (exp_stall + 1 + delay > 15) ? 15 : exp_stall + 1 + delay;
        @(negedge clock);
        check("done_stall", 32'(stall), 32'd0);
        check("done_req", 32'(sram_req), 32'd0);
        check("done_addr", sram_addr, addr);
        check("done_buserr", 32'(bus_err), 32'(!ack_en));
        check("done_rdata", data_read_mem, exp_q.pop_front());
        check("done_stallcnt", 32'(stall_cycles), 32'(exp_stall));
        $display("access addr=%h be=%h delay=%0d ack=%0d rdata=%h stall_cycles=%0d",
                 addr, be, delay, ack_en, data_read_mem, stall_cycles);
    endtask

    initial begin
        reset          = 1'b0;
        access_mem     = 1'b0;
        addr_mem       = '0;
        data_write_mem = '0;
        data_we_mem    = '0;
        sram_ack       = 1'b0;
        sram_rdata     = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_state_req", 32'(sram_req), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_rdata", data_read_mem, 32'd0);
        check("rst_stallcnt", 32'(stall_cycles), 32'd0);
        check("rst_buserr", 32'(bus_err), 32'd0);
        reset = 1'b1;
        $display("reset released");

        // Read, ack on first REQ cycle: 2 stalled cycles.
        access(32'h4000_0010, 32'h0, 4'b0000, 1, 32'h1234_5678, 1'b1, 1'b0);
        // Byte write, ack after 5 REQ cycles: 6 stalled cycles, rdata kept.
        access(32'h4000_0020, 32'hAABB_CCDD, 4'b0010, 5, 32'h5555_5555, 1'b1, 1'b0);
        // Back-to-back: access_mem held across DONE, second capture after DONE.
        access(32'h4000_0030, 32'h0, 4'b0000, 1, 32'hCAFE_0001, 1'b1, 1'b1);
        access(32'h4000_0034, 32'h0, 4'b0000, 1, 32'hCAFE_0002, 1'b1, 1'b0);
        // 20 stalled cycles saturate the 4-bit counter, then it stays at F.
        access(32'h4000_0040, 32'h0, 4'b0000, 19, 32'h0BAD_F00D, 1'b1, 1'b0);
        check("sat_stallcnt", 32'(stall_cycles), 32'hF);
        access(32'h4000_0044, 32'h1111_2222, 4'b1111, 2, 32'h0, 1'b1, 1'b0);
        check("sat_nowrap", 32'(stall_cycles), 32'hF);

        // Async reset mid-REQ, then a stray ack must be ignored.
        @(posedge clock); #1;
        access_mem     = 1'b1;
        addr_mem       = 32'h4000_0050;
        data_write_mem = 32'h0;
        data_we_mem    = 4'b0000;
        @(posedge clock); #1;
        access_mem = 1'b0;
        @(negedge clock);
        check("pre_rst_req", 32'(sram_req), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("arst_req", 32'(sram_req), 32'd0);
        check("arst_stall", 32'(stall), 32'd0);
        check("arst_addr", sram_addr, 32'd0);
        check("arst_rdata", data_read_mem, 32'd0);
        check("arst_stallcnt", 32'(stall_cycles), 32'd0);
        sram_ack   = 1'b1;
        sram_rdata = 32'h7777_7777;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        @(negedge clock);
        check("stray_req", 32'(sram_req), 32'd0);
        check("stray_stall", 32'(stall), 32'd0);
        check("stray_rdata", data_read_mem, 32'd0);
        sram_ack  = 1'b0;
        exp_data  = 32'h0;
        exp_stall = 0;
        $display("async reset mid-REQ done, sram_req=%0d stall=%0d", sram_req, stall);

`ifdef HFRV_MEM_BRIDGE_TIMEOUT_EN
        // No ack: expires after TO REQ cycles with bus_err and ERR_RDATA.
        access(32'h4000_0060, 32'h0, 4'b0000, TO, 32'h0, 1'b0, 1'b0);
        @(posedge clock); #1;
        @(negedge clock);
        check("buserr_pulse_end", 32'(bus_err), 32'd0);
        // Ack exactly on the expiry cycle wins.
        access(32'h4000_0064, 32'h0, 4'b0000, TO, 32'h600D_DA7A, 1'b1, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/hfrv_mem_bridge.md
Name: hfrv_mem_bridge

Overview:
- Memory-side stage directly downstream of the peripherals bus mux.
- Accepts the mux's single-cycle memory port (address, write data, byte enables) and converts each access into a req/ack transaction toward a slow external SRAM/flash model.
- Asserts stall back through the mux to freeze the datapath until the data phase completes.
- Also keeps a saturating count of stall cycles for performance analysis.

Parameters:
- ADDR_W, 32, width of address bus.
- DATA_W, 32, width of data bus; byte-enable width is DATA_W/8.
- TIMEOUT_CYCLES, 255, max cycles awaiting sram_ack (used only with the optional feature).
- CNT_W, 32, width of stall-cycle counter.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- access_mem  in  1  mux requests a memory access this cycle.
- addr_mem  in  ADDR_W  access address (word aligned; bits [1:0] forwarded unchanged).
- data_write_mem  in  DATA_W  write data.
- data_we_mem  in  DATA_W/8  byte write enables; all-zero means read.
- data_read_mem  out  DATA_W  read data returned to mux.
- stall  out  1  freeze request to mux/datapath.
- sram_req  out  1  transaction request to memory.
- sram_we  out  1  write transaction (OR of captured byte enables).
- sram_be  out  DATA_W/8  captured byte enables.
- sram_addr  out  ADDR_W  captured address.
- sram_wdata  out  DATA_W  captured write data.
- sram_ack  in  1  one-cycle completion pulse; sram_rdata valid in the same cycle.
- sram_rdata  in  DATA_W  read data from memory.
- bus_err  out  1  one-cycle pulse on timeout (optional feature, else 0).
- stall_cycles  out  CNT_W  saturating count of cycles with stall=1.

Behaviour:
- FSM states: IDLE, REQ, DONE.
- Reset (reset=0, async):
  - State goes to IDLE.
  - sram_req=0; sram_* capture registers=0.
  - data_read_mem=0; stall_cycles=0; bus_err=0.
  - Takes effect immediately even mid-transaction; sram_req drops without waiting for ack.
- IDLE:
  - If access_mem=1: capture addr/wdata/be into the sram_* registers and go to REQ next edge.
  - stall is combinational, =1 in the capture cycle.
- REQ:
  - sram_req=1 and stall=1.
  - sram_* outputs stable, held unchanged until ack.
  - On sram_ack=1: register sram_rdata into data_read_mem (writes leave data_read_mem unchanged), deassert sram_req next edge, go to DONE.
- DONE:
  - stall=0 for exactly one cycle; the datapath consumes data_read_mem and advances. Then go to IDLE.
  - access_mem in the DONE cycle belongs to the completing access and is ignored.
- stall = (IDLE & access_mem) | REQ.
- Minimum access latency: 1 capture cycle + 1 REQ cycle (ack on first REQ cycle) + DONE = 2 stalled cycles.
- sram_ack while in IDLE or DONE: ignored, no state change.
- stall_cycles:
  - Increments each cycle stall=1.
  - Saturates at all-ones; never wraps.
- data_read_mem holds its last value between accesses.

Optional Feature:
- Macro: HFRV_MEM_BRIDGE_TIMEOUT_EN.
- With the macro defined:
  - A timeout counter clears on entry to REQ and increments each REQ cycle without ack.
  - When it reaches TIMEOUT_CYCLES: drop sram_req, load data_read_mem=32'hDEADBEEF (reads only), pulse bus_err for 1 cycle aligned with entry to DONE, then go to DONE.
  - An ack arriving in the same cycle as expiry wins: normal completion, no bus_err.
- Without the macro:
  - No timeout counter; REQ waits indefinitely.
  - bus_err tied to 0.

Decomposition:
- Package hfrv_mem_bridge_pkg:
  - State enum (IDLE, REQ, DONE).
  - Constant ERR_RDATA = 32'hDEADBEEF.
  - Default parameter constants.
- One natural sub-module: hfrv_sat_counter (parameterised width, enable, async active-low clear), used for stall_cycles and the timeout counter.

Test Plan:
- Read, ack on first REQ cycle:
  - Stimulus: addr=0x40000010, we=0, sram_rdata=0x12345678.
  - Expect: stall high 2 cycles, data_read_mem=0x12345678 in DONE, stall_cycles=2.
- Byte write with 5-cycle ack delay:
  - Stimulus: we=4'b0010, wdata=0xAABBCCDD.
  - Expect: sram_we=1, sram_be=0010, sram_* stable for 5 REQ cycles, data_read_mem unchanged, stall high 6 cycles.
- Back-to-back accesses:
  - Stimulus: access_mem held high across DONE.
  - Expect: exactly one transaction per DONE; second capture occurs in the cycle after DONE.
- Async reset mid-REQ:
  - Stimulus: reset=0 asserted between edges.
  - Expect: sram_req and stall drop immediately, outputs 0, FSM IDLE; stray ack after reset ignored.
- Timeout (macro on, TIMEOUT_CYCLES=4):
  - Stimulus: no ack.
  - Expect: bus_err single pulse, data_read_mem=0xDEADBEEF.
  - Repeat with ack on the expiry cycle: normal rdata, bus_err=0.
- Counter saturation (CNT_W=4):
  - Stimulus: 20 stalled cycles.
  - Expect: stall_cycles=4'hF, no wrap.
